// File: rtl/alu_seq_unit.sv
// alu_seq_unit: registered 32-bit execute stage with valid/ready handshakes.
// Single-cycle logic/arithmetic ops, iterative 1-bit/cycle shifts and a
// 32-step shift-add multiply. The result/flag registers change only on
// entry to DONE, so the downstream zero flag stays stable between completions.
module alu_seq_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       command,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow
);

    localparam logic [3:0] CMD_ADD  = 4'd0;
    localparam logic [3:0] CMD_SUB  = 4'd1;
    localparam logic [3:0] CMD_XOR  = 4'd2;
    localparam logic [3:0] CMD_SLT  = 4'd3;
    localparam logic [3:0] CMD_AND  = 4'd4;
    localparam logic [3:0] CMD_NAND = 4'd5;
    localparam logic [3:0] CMD_NOR  = 4'd6;
    localparam logic [3:0] CMD_OR   = 4'd7;
    localparam logic [3:0] CMD_SLL  = 4'd8;
    localparam logic [3:0] CMD_SRL  = 4'd9;
    localparam logic [3:0] CMD_SRA  = 4'd10;
    localparam logic [3:0] CMD_MUL  = 4'd11;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_next;
    logic [3:0]       cmd_q;
    logic [WIDTH-1:0] work_q;   // shift operand, or multiplier/low product
    logic [WIDTH-1:0] mcand_q;  // multiplicand
    logic [WIDTH-1:0] hi_q;     // high half of the running product
    logic [4:0]       cnt_q;

    logic             is_multi;
    logic [WIDTH:0]   sum33;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_work, step_hi;
    logic             step_bit;

    // Requests needing BUSY: any multiply, or a shift by a nonzero amount.
    assign is_multi = (command == CMD_MUL) ||
                      ((command == CMD_SLL || command == CMD_SRL || command == CMD_SRA) &&
                       (operandB[4:0] != 5'd0));

    // Single-cycle result and flags, evaluated from the live inputs at accept.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        sum33   = '0;
        case (command)
            CMD_ADD: begin
                sum33   = {1'b0, operandA} + {1'b0, operandB};
                alu_res = sum33[WIDTH-1:0];
                alu_c   = sum33[WIDTH];
                alu_v   = (operandA[WIDTH-1] == operandB[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != operandA[WIDTH-1]);
            end
            CMD_SUB: begin
                sum33   = {1'b0, operandA} + {1'b0, ~operandB} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = sum33[WIDTH-1:0];
                alu_c   = sum33[WIDTH];
                alu_v   = (operandA[WIDTH-1] != operandB[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != operandA[WIDTH-1]);
            end
            CMD_XOR:  alu_res = operandA ^ operandB;
            // Direct signed compare, so it stays right when A-B overflows.
            CMD_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(operandA) < $signed(operandB))};
            CMD_AND:  alu_res = operandA & operandB;
            CMD_NAND: alu_res = ~(operandA & operandB);
            CMD_NOR:  alu_res = ~(operandA | operandB);
            CMD_OR:   alu_res = operandA | operandB;
            // Only reached with a zero shift amount: result is A, no bit shifted out.
            CMD_SLL, CMD_SRL, CMD_SRA: alu_res = operandA;
            default:  alu_res = '0;
        endcase
    end

    // One iteration of the latched multi-cycle operation.
    always_comb begin
        step_work = work_q;
        step_hi   = hi_q;
        step_bit  = 1'b0;
        mul_sum   = '0;
        case (cmd_q)
            CMD_SLL: begin
                step_work = {work_q[WIDTH-2:0], 1'b0};
                step_bit  = work_q[WIDTH-1];
            end
            CMD_SRL: begin
                step_work = {1'b0, work_q[WIDTH-1:1]};
                step_bit  = work_q[0];
            end
            CMD_SRA: begin
                step_work = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                step_bit  = work_q[0];
            end
            CMD_MUL: begin
                mul_sum   = {1'b0, hi_q} + (work_q[0] ? {1'b0, mcand_q} : '0);
                step_hi   = mul_sum[WIDTH:1];
                step_work = {mul_sum[0], work_q[WIDTH-1:1]};
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; handshake outputs decode registered state only.
    always_comb begin
        state_next = state;
        in_ready   = (state == IDLE);
        out_valid  = (state == DONE);
        case (state)
            IDLE: if (in_valid) state_next = is_multi ? BUSY : DONE;
            BUSY: if (cnt_q == 5'd0) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch on accept, iterate in BUSY, write outputs on entry to DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q    <= '0;
            work_q   <= '0;
            mcand_q  <= '0;
            hi_q     <= '0;
            cnt_q    <= '0;
            result   <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            cmd_q   <= command;
            work_q  <= operandA;
            mcand_q <= operandB;
            hi_q    <= '0;
            cnt_q   <= (command == CMD_MUL) ? 5'(MUL_CYCLES - 1) : (operandB[4:0] - 5'd1);
            if (!is_multi) begin
                result   <= alu_res;
                carryout <= alu_c;
                overflow <= alu_v;
            end
        end else if (state == BUSY) begin
            work_q <= step_work;
            hi_q   <= step_hi;
            if (cnt_q == 5'd0) begin
                result   <= step_work;
                carryout <= (cmd_q == CMD_MUL) ? (|step_hi) : step_bit;
                overflow <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: hand-computed results, flags and latencies.
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_seq_unit;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  command;
    logic [31:0] operandA, operandB, result;
    logic        carryout, overflow;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_seq_unit dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .command   (command),
        .operandA  (operandA),
        .operandB  (operandB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carryout  (carryout),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op with out_ready high; check latency, result, flags, zero.
    task automatic run_op(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_r,
                          input logic exp_c, input logic exp_v);
        int lat;
        check({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
        command  = cmd;
        operandA = a;
        operandB = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".result"}, result, exp_r);
        check({tag, ".carry"}, {31'b0, carryout}, {31'b0, exp_c});
        check({tag, ".ovf"}, {31'b0, overflow}, {31'b0, exp_v});
        check({tag, ".zero"}, {31'b0, (result == 32'd0)}, {31'b0, (exp_r == 32'd0)});
        @(negedge clk);  // DONE -> IDLE with out_ready high
    endtask

    initial begin
        logic seen;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        command = '0; operandA = '0; operandB = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst.in_ready", {31'b0, in_ready}, 32'd1);
        check("rst.out_valid", {31'b0, out_valid}, 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.flags", {30'b0, carryout, overflow}, 32'd0);

        run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 1'b1, 1'b0);
        run_op("add_ovf",  4'd0, 32'h7FFF_FFFF, 32'd1, 1, 32'h8000_0000, 1'b0, 1'b1);
        run_op("sub_ovf",  4'd1, 32'h8000_0000, 32'd1, 1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_op("sub_brw",  4'd1, 32'd3, 32'd5, 1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("slt_ovf",  4'd3, 32'h8000_0000, 32'd1, 1, 32'd1, 1'b0, 1'b0);
        run_op("slt_no",   4'd3, 32'd1, 32'h8000_0000, 1, 32'd0, 1'b0, 1'b0);
        run_op("xor",      4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'h0FF0_0FF0, 1'b0, 1'b0);
        run_op("and",      4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hF000_F000, 1'b0, 1'b0);
        run_op("nand",     4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'h0FFF_0FFF, 1'b0, 1'b0);
        run_op("nor",      4'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'h000F_000F, 1'b0, 1'b0);
        run_op("or",       4'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hFFF0_FFF0, 1'b0, 1'b0);
        run_op("sra4",     4'd10, 32'h8000_0010, 32'd4, 5, 32'hF800_0001, 1'b0, 1'b0);
        run_op("sll0",     4'd8, 32'h1234_5678, 32'd0, 1, 32'h1234_5678, 1'b0, 1'b0);
        run_op("srl1",     4'd9, 32'h8000_0001, 32'd1, 2, 32'h4000_0000, 1'b1, 1'b0);
        run_op("sll31",    4'd8, 32'h0000_0003, 32'd31, 32, 32'h8000_0000, 1'b1, 1'b0);
        run_op("rsvd",     4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'd0, 1'b0, 1'b0);
        run_op("mul_big",  4'd11, 32'h0001_0000, 32'h0001_0000, 33, 32'd0, 1'b1, 1'b0);
        run_op("mul_7x6",  4'd11, 32'd7, 32'd6, 33, 32'd42, 1'b0, 1'b0);

        // Backpressure: hold DONE, ignore a new request, then take it after release.
        out_ready = 1'b0;
        command = 4'd0; operandA = 32'd5; operandB = 32'd3; in_valid = 1'b1;
        @(negedge clk);
        check("bp.done", {31'b0, out_valid}, 32'd1);
        command = 4'd2; operandA = 32'hAAAA_0000; operandB = 32'h00FF_00FF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp.hold_result", result, 32'd8);
            check("bp.hold_ready", {31'b0, in_ready}, 32'd0);
            check("bp.hold_valid", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp.idle_ready", {31'b0, in_ready}, 32'd1);
        check("bp.idle_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp.pend_valid", {31'b0, out_valid}, 32'd1);
        check("bp.pend_result", result, 32'hAA55_00FF);
        @(negedge clk);

        // Reset and accept on the same edge: reset wins.
        reset = 1'b1; in_valid = 1'b1; command = 4'd7;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        check("rstpri.in_ready", {31'b0, in_ready}, 32'd1);
        check("rstpri.out_valid", {31'b0, out_valid}, 32'd0);

        // Give result a nonzero value, then abort a MUL on its 10th cycle.
        run_op("pre_abort", 4'd7, 32'h0000_0100, 32'd0, 1, 32'h0000_0100, 1'b0, 1'b0);
        command = 4'd11; operandA = 32'd9; operandB = 32'd9; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort.in_ready", {31'b0, in_ready}, 32'd1);
        check("abort.out_valid", {31'b0, out_valid}, 32'd0);
        check("abort.result", result, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort.no_completion", {31'b0, seen}, 32'd0);
        check("abort.result_hold", result, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
Registered 32-bit execute stage that sits directly upstream of the zero-flag checker. The checker's zero flag is a pure function of this block's result bus.
- Single-cycle ops: the eight Lab1 ALU commands.
- Multi-cycle ops: iterative shifts (1 bit/cycle) and a shift-add multiply (32 cycles).
- Valid/ready handshake on both sides.

Parameters:
WIDTH, 32, datapath width. Only 32 is supported; other values are illegal.
MUL_CYCLES, 32, multiply iteration count. Must equal WIDTH.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  block can accept a request (state IDLE)
command  input  4  operation select, encoding below
operandA  input  32  first operand
operandB  input  32  second operand; [4:0] is the shift amount for shifts
out_valid  output  1  result/flags valid (state DONE)
out_ready  input  1  consumer accepts the result
result  output  32  registered result; drives the zero checker directly
carryout  output  1  registered carry flag
overflow  output  1  registered signed-overflow flag

Behaviour:
- Command encoding:
  - 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.
  - 8 SLL, 9 SRL, 10 SRA, 11 MUL (low 32 bits, unsigned).
  - 12-15 reserved.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - Both are decoded from registered state only; no combinational path from any input.
- Accept: in_valid && in_ready at a clock edge latches command and both operands.
  - Inputs are ignored in BUSY and DONE.
- Latency, counted from the accept edge to the edge where out_valid rises:
  - commands 0-7 and 12-15: 1 cycle (IDLE->DONE);
  - shifts with shamt=0: 1 cycle;
  - shifts with shamt=N (1-31): N+1 cycles (IDLE->BUSY, N-1 further BUSY cycles, ->DONE);
  - MUL: MUL_CYCLES+1 cycles.
  - BUSY uses an internal 5-bit down-counter. Leave BUSY when the counter reaches 0.
- DONE -> IDLE on out_valid && out_ready. There is no same-edge re-accept, so the peak rate is one op per 2 cycles.
- result, carryout and overflow are written only on the edge entering DONE. They hold their value through DONE, IDLE and BUSY until the next completion, so the downstream zero flag is stable between completions.
- Arithmetic and flags:
  - ADD: {carryout,result} = A+B (33-bit). overflow = (A[31]==B[31]) && (result[31]!=A[31]).
  - SUB: computed as A + ~B + 1. carryout is the carry out of that sum (1 = no borrow). overflow = (A[31]!=B[31]) && (result[31]!=A[31]).
  - SLT: result = {31'b0, signed(A)<signed(B)}. Must be correct even when A-B overflows (e.g. A=0x80000000, B=1 gives 1). carryout=overflow=0.
  - XOR/AND/NAND/NOR/OR: bitwise. carryout=overflow=0.
  - SLL/SRL/SRA: carryout = last bit shifted out (0 when shamt=0). overflow=0. SRA replicates A[31].
  - MUL: result = low 32 bits of unsigned A*B. carryout = 1 iff the high 32 bits are nonzero. overflow=0.
  - Reserved 12-15: result=0, carryout=overflow=0.
- Reset:
  - At a reset edge: state<=IDLE, result<=0, carryout<=0, overflow<=0, counter<=0.
  - After reset, in_ready=1 and out_valid=0. Downstream zero reads 1 because result=0.
  - Reset mid-BUSY or in DONE aborts the operation and produces no completion.
  - Reset takes priority over every other event on the same edge, including an accept.
- in_valid held with in_ready low is not an error. The request is taken on the first edge where state is IDLE.
- out_ready held high in IDLE/BUSY has no effect.

Test Plan:
- Reset, then ADD A=0xFFFFFFFF, B=1, out_ready=1 -> out_valid one cycle after accept; result=0, carryout=1, overflow=0; downstream zero=1.
- SUB A=0x80000000, B=1 -> result=0x7FFFFFFF, overflow=1, carryout=1. Then SLT with the same operands -> result=1, flags 0.
- SRA A=0x80000010, B=4 -> out_valid 5 cycles after accept; result=0xF8000001, carryout=0. SLL with B=0 -> 1-cycle latency, result=A, carryout=0.
- MUL A=0x00010000, B=0x00010000 -> out_valid 33 cycles after accept; result=0, carryout=1. MUL 7*6 -> result=42, carryout=0.
- Backpressure: out_ready=0 for 10 cycles after DONE -> result/flags stable, in_ready=0, a new in_valid is ignored. Raise out_ready -> IDLE next edge; the pending request is accepted the edge after.
- Reset asserted on cycle 10 of a MUL -> next cycle state IDLE, out_valid=0, result=0; no completion ever appears for the aborted op.
